alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/alu_iter_unit.sv | 81 ++++++++
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 tb/tb_alu_op_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU sequencer: opcodes, FSM states,
// result bundle and the single-cycle operation helper.
package alu_pkg;

   localparam int DATA_W     = 4;
   localparam int RES_W      = 8;
   localparam int ITER_STEPS = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOTA = 4'd7,
      OP_NOTB = 4'd8
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      ITER,
      DONE
   } state_t;

   typedef struct packed {
      logic [RES_W-1:0]  data;
      logic [DATA_W-1:0] rem;
      logic              err;
   } result_t;

   function automatic result_t exec_op(input opcode_t op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
      result_t          r;
      logic [RES_W-1:0] a_x;
      logic [RES_W-1:0] b_x;
      r   = '0;
      a_x = {{(RES_W-DATA_W){1'b0}}, a};
      b_x = {{(RES_W-DATA_W){1'b0}}, b};
      case (op)
         OP_ADD:  r.data = a_x + b_x;
         OP_SUB:  r.data = a_x - b_x;
         // MUL only reaches the single-cycle path when B is zero
         OP_MUL:  r.data = '0;
         OP_DIV: begin
            r.data = '1;
            r.rem  = a;
            r.err  = 1'b1;
         end
         OP_AND:  r.data = a_x & b_x;
         OP_OR:   r.data = a_x | b_x;
         OP_XOR:  r.data = a_x ^ b_x;
         OP_NOTA: r.data = {{(RES_W-DATA_W){1'b0}}, ~a};
         OP_NOTB: r.data = {{(RES_W-DATA_W){1'b0}}, ~b};
         default: r.err  = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative MUL (shift-add, LSB of B first) and DIV (restoring, MSB first) engine.
// Loaded on start, then runs one step per cycle; done marks the final step.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int STEPS = ITER_STEPS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  opcode_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [RES_W-1:0]  result,
   output logic [DATA_W-1:0] remainder
);

   localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic              running;
   logic              is_div;
   logic [CW-1:0]     step_cnt;
   logic [RES_W-1:0]  acc;
   logic [RES_W-1:0]  mcand;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] divisor;

   logic [RES_W-1:0]  acc_next;
   logic [DATA_W:0]   trial;
   logic              fits;
   logic [DATA_W-1:0] rem_next;
   logic [DATA_W-1:0] quo_next;

   // shreg holds the multiplier for MUL and the dividend/quotient for DIV
   always_comb begin
      acc_next  = acc + (shreg[0] ? mcand : '0);
      trial     = {rem_q, shreg[DATA_W-1]};
      fits      = (trial >= {1'b0, divisor});
      rem_next  = fits ? DATA_W'(trial - {1'b0, divisor}) : trial[DATA_W-1:0];
      quo_next  = {shreg[DATA_W-2:0], fits};
      done      = running && (step_cnt == CW'(STEPS - 1));
      result    = is_div ? {{(RES_W-DATA_W){1'b0}}, quo_next} : acc_next;
      remainder = is_div ? rem_next : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running  <= 1'b0;
         is_div   <= 1'b0;
         step_cnt <= '0;
         acc      <= '0;
         mcand    <= '0;
         shreg    <= '0;
         rem_q    <= '0;
         divisor  <= '0;
      end else if (start) begin
         running  <= 1'b1;
         is_div   <= (op == OP_DIV);
         step_cnt <= '0;
         acc      <= '0;
         mcand    <= {{(RES_W-DATA_W){1'b0}}, a};
         shreg    <= (op == OP_DIV) ? a : b;
         rem_q    <= '0;
         divisor  <= b;
      end else if (running) begin
         if (done) begin
            running  <= 1'b0;
            step_cnt <= '0;
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
         acc   <= acc_next;
         mcand <= mcand << 1;
         shreg <= is_div ? quo_next : (shreg >> 1);
         rem_q <= rem_next;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer around the 4-bit ALU: valid/ready command intake,
// single-cycle or iterative execution, held result and saturating op counter.
module alu_op_sequencer #(
   parameter int CNT_W      = 16,
   parameter int ITER_STEPS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic [3:0]       res_rem,
   output logic             res_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   import alu_pkg::*;

   state_t            state;
   opcode_t           op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   opcode_t           cmd_opcode;
   logic              handshake;
   logic              to_iter;
   result_t           exec_res;

   logic              iter_done;
   logic [RES_W-1:0]  iter_result;
   logic [DATA_W-1:0] iter_rem;

   assign cmd_ready  = (state == IDLE) && !rst;
   assign busy       = (state != IDLE);
   assign cmd_opcode = opcode_t'(cmd_op);
   assign handshake  = cmd_valid && cmd_ready;
   assign to_iter    = ((cmd_opcode == OP_MUL) || (cmd_opcode == OP_DIV)) && (cmd_b != '0);
   assign exec_res   = exec_op(op_q, a_q, b_q);

   alu_iter_unit #(
      .STEPS(ITER_STEPS)
   ) u_iter (
      .clk       (clk),
      .rst       (rst),
      .start     (handshake && to_iter),
      .op        (cmd_opcode),
      .a         (cmd_a),
      .b         (cmd_b),
      .done      (iter_done),
      .result    (iter_result),
      .remainder (iter_rem)
   );

   // Control FSM; result registers only change on entry to DONE so they stay
   // stable for the whole time res_valid is high
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_rem   <= '0;
         res_err   <= 1'b0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  op_q  <= cmd_opcode;
                  a_q   <= cmd_a;
                  b_q   <= cmd_b;
                  state <= to_iter ? ITER : EXEC;
               end
            end
            EXEC: begin
               res_data  <= exec_res.data;
               res_rem   <= exec_res.rem;
               res_err   <= exec_res.err;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            ITER: begin
               if (iter_done) begin
                  res_data  <= iter_result;
                  res_rem   <= iter_rem;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
                  if (op_count != '1) begin
                     op_count <= op_count + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer, with a second instance
// using a 2-bit counter to exercise op_count saturation.
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [3:0]  cmd_a;
   logic [3:0]  cmd_b;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [3:0]  res_rem;
   logic        res_err;
   logic        busy;
   logic [15:0] op_count;

   logic        sat_cmd_ready;
   logic        sat_res_valid;
   logic [7:0]  sat_res_data;
   logic [3:0]  sat_res_rem;
   logic        sat_res_err;
   logic        sat_busy;
   logic [1:0]  sat_op_count;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int exp_count = 0;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] data;
      logic [3:0] rem;
      logic       err;
   } vec_t;

   vec_t vecs[13];

   alu_op_sequencer #(.CNT_W(16), .ITER_STEPS(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_rem(res_rem),
      .res_err(res_err), .busy(busy), .op_count(op_count)
   );

   alu_op_sequencer #(.CNT_W(2), .ITER_STEPS(4)) dut_sat (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(sat_cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(sat_res_valid),
      .res_ready(res_ready), .res_data(sat_res_data), .res_rem(sat_res_rem),
      .res_err(sat_res_err), .busy(sat_busy), .op_count(sat_op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d", check_cnt);
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one handshake cycle, then scrambles the operands to show they were latched
   task automatic send_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = ~op;
      cmd_a     = ~a;
      cmd_b     = ~b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_cnt++;
      if ({cmd_ready, res_valid, busy} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {cmd_ready, res_valid, busy});
      else pass_cnt++;
      check_cnt++;
      if ({res_data, res_rem, res_err} !== 13'h0) $display("[TB] FAIL reset_result: got %h expected 0", {res_data, res_rem, res_err});
      else pass_cnt++;
      check_cnt++;
      if (op_count !== 16'd0) $display("[TB] FAIL reset_count: got %0d expected 0", op_count);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      check_cnt++;
      if (cmd_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b expected 1", cmd_ready);
      else pass_cnt++;
      exp_count = 0;
   endtask

   // Runs one table entry through the single-cycle path with res_ready held high
   task automatic run_vec(input int i);
      check_cnt++;
      if (cmd_ready !== 1'b1) $display("[TB] FAIL vec%0d_ready: got %b expected 1", i, cmd_ready);
      else pass_cnt++;
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      check_cnt++;
      if ({res_valid, busy} !== 2'b01) $display("[TB] FAIL vec%0d_cycle1: valid/busy got %b expected 01", i, {res_valid, busy});
      else pass_cnt++;
      tick();
      check_cnt++;
      if (res_valid !== 1'b1) $display("[TB] FAIL vec%0d_latency: res_valid got %b expected 1", i, res_valid);
      else pass_cnt++;
      check_cnt++;
      if ({res_data, res_rem, res_err} !== {vecs[i].data, vecs[i].rem, vecs[i].err})
         $display("[TB] FAIL vec%0d_result: data/rem/err got %h/%h/%b expected %h/%h/%b",
                  i, res_data, res_rem, res_err, vecs[i].data, vecs[i].rem, vecs[i].err);
      else pass_cnt++;
      tick();
      exp_count++;
   endtask

   task automatic test_single_cycle();
      vecs[0]  = '{4'd0, 4'd13, 4'd10, 8'h17, 4'd0, 1'b0};
      vecs[1]  = '{4'd1, 4'd13, 4'd10, 8'h03, 4'd0, 1'b0};
      vecs[2]  = '{4'd4, 4'd13, 4'd10, 8'h08, 4'd0, 1'b0};
      vecs[3]  = '{4'd1, 4'd3,  4'd5,  8'hFE, 4'd0, 1'b0};
      vecs[4]  = '{4'd3, 4'd9,  4'd0,  8'hFF, 4'd9, 1'b1};
      vecs[5]  = '{4'd15, 4'd6, 4'd7,  8'h00, 4'd0, 1'b1};
      vecs[6]  = '{4'd5, 4'd13, 4'd10, 8'h0F, 4'd0, 1'b0};
      vecs[7]  = '{4'd6, 4'd13, 4'd10, 8'h07, 4'd0, 1'b0};
      vecs[8]  = '{4'd7, 4'd13, 4'd10, 8'h02, 4'd0, 1'b0};
      vecs[9]  = '{4'd8, 4'd13, 4'd10, 8'h05, 4'd0, 1'b0};
      vecs[10] = '{4'd2, 4'd7,  4'd0,  8'h00, 4'd0, 1'b0};
      vecs[11] = '{4'd0, 4'd15, 4'd15, 8'h1E, 4'd0, 1'b0};
      vecs[12] = '{4'd9, 4'd5,  4'd3,  8'h00, 4'd0, 1'b1};
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) run_vec(i);
      check_cnt++;
      if (op_count !== 16'(exp_count)) $display("[TB] FAIL count_after_three: got %0d expected %0d", op_count, exp_count);
      else pass_cnt++;
   endtask

   task automatic test_edge_cases();
      res_ready = 1'b1;
      for (int i = 3; i < 13; i++) run_vec(i);
      check_cnt++;
      if (op_count !== 16'(exp_count)) $display("[TB] FAIL count_after_edges: got %0d expected %0d", op_count, exp_count);
      else pass_cnt++;
   endtask

   task automatic test_iterative();
      logic [3:0] ops[2];
      logic [7:0] exp_data[2];
      logic [3:0] exp_rem[2];
      ops[0] = 4'd2; exp_data[0] = 8'h82; exp_rem[0] = 4'd0;
      ops[1] = 4'd3; exp_data[1] = 8'h01; exp_rem[1] = 4'd3;
      res_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         send_cmd(ops[k], 4'd13, 4'd10);
         for (int c = 1; c <= 4; c++) begin
            check_cnt++;
            if ({res_valid, busy, cmd_ready} !== 3'b010)
               $display("[TB] FAIL iter%0d_cycle%0d: valid/busy/ready got %b expected 010", k, c, {res_valid, busy, cmd_ready});
            else pass_cnt++;
            tick();
         end
         check_cnt++;
         if ({res_valid, busy} !== 2'b11) $display("[TB] FAIL iter%0d_latency: valid/busy got %b expected 11", k, {res_valid, busy});
         else pass_cnt++;
         check_cnt++;
         if ({res_data, res_rem, res_err} !== {exp_data[k], exp_rem[k], 1'b0})
            $display("[TB] FAIL iter%0d_result: data/rem/err got %h/%h/%b expected %h/%h/0",
                     k, res_data, res_rem, res_err, exp_data[k], exp_rem[k]);
         else pass_cnt++;
         tick();
         exp_count++;
         check_cnt++;
         if (busy !== 1'b0) $display("[TB] FAIL iter%0d_idle: busy got %b expected 0", k, busy);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      send_cmd(4'd2, 4'd15, 4'd15);
      for (int c = 1; c <= 4; c++) begin
         cmd_valid = (c == 3);
         cmd_op    = 4'd0;
         cmd_a     = 4'd1;
         cmd_b     = 4'd1;
         tick();
      end
      for (int h = 0; h < 4; h++) begin
         cmd_valid = (h % 2 == 0);
         check_cnt++;
         if ({res_valid, cmd_ready, res_data} !== {1'b1, 1'b0, 8'hE1})
            $display("[TB] FAIL hold%0d: valid/ready/data got %b/%b/%h expected 1/0/e1", h, res_valid, cmd_ready, res_data);
         else pass_cnt++;
         tick();
      end
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      check_cnt++;
      if ({res_valid, res_data} !== {1'b1, 8'hE1}) $display("[TB] FAIL hold_accept: valid/data got %b/%h expected 1/e1", res_valid, res_data);
      else pass_cnt++;
      tick();
      cmd_valid = 1'b0;
      exp_count++;
      check_cnt++;
      if ({res_valid, busy} !== 2'b00) $display("[TB] FAIL hold_release: valid/busy got %b expected 00", {res_valid, busy});
      else pass_cnt++;
      check_cnt++;
      if (op_count !== 16'(exp_count)) $display("[TB] FAIL hold_count: got %0d expected %0d", op_count, exp_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_op();
      res_ready = 1'b1;
      send_cmd(4'd3, 4'd13, 4'd10);
      tick();
      rst = 1'b1;
      tick();
      exp_count = 0;
      check_cnt++;
      if ({busy, res_valid, cmd_ready} !== 3'b000) $display("[TB] FAIL midreset_state: busy/valid/ready got %b expected 000", {busy, res_valid, cmd_ready});
      else pass_cnt++;
      check_cnt++;
      if (op_count !== 16'd0) $display("[TB] FAIL midreset_count: got %0d expected 0", op_count);
      else pass_cnt++;
      rst = 1'b0;
      tick();
      tick();
      check_cnt++;
      if ({res_valid, busy, op_count} !== {2'b00, 16'd0}) $display("[TB] FAIL stray_ready: valid/busy/count got %b/%b/%0d expected 0/0/0", res_valid, busy, op_count);
      else pass_cnt++;
      send_cmd(4'd0, 4'd1, 4'd1);
      tick();
      check_cnt++;
      if ({res_valid, res_data, res_err} !== {1'b1, 8'h02, 1'b0}) $display("[TB] FAIL fresh_add: valid/data/err got %b/%h/%b expected 1/02/0", res_valid, res_data, res_err);
      else pass_cnt++;
      tick();
      exp_count++;
   endtask

   task automatic test_saturation();
      res_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_count = 0;
      for (int n = 0; n < 5; n++) begin
         send_cmd(4'd0, 4'(n), 4'd1);
         tick();
         tick();
         exp_count++;
      end
      check_cnt++;
      if (sat_op_count !== 2'd3) $display("[TB] FAIL sat_count: got %0d expected 3", sat_op_count);
      else pass_cnt++;
      check_cnt++;
      if (op_count !== 16'(exp_count)) $display("[TB] FAIL wide_count: got %0d expected %0d", op_count, exp_count);
      else pass_cnt++;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_a     = 4'd0;
      cmd_b     = 4'd0;
      res_ready = 1'b0;
      test_reset();
      test_single_cycle();
      test_iterative();
      test_edge_cases();
      test_backpressure();
      test_reset_mid_op();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
